// File: rtl/writeback_etapa_pkg.sv
// Shared constants for the decode, memory and writeback stages: load-type codes,
// default byte-lane ordering and the writeback stage-register layout.
package writeback_etapa_pkg;

  localparam bit DEFAULT_BIG_ENDIAN = 1'b1;
  localparam int DEFAULT_CNT_W      = 32;

  // Codes 101-111 are not listed and fall through to word loads everywhere.
  typedef enum logic [2:0] {
    LOAD_LW  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LHU = 3'b010,
    LOAD_LB  = 3'b011,
    LOAD_LBU = 3'b100
  } load_type_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [2:0]  load_type;
    logic [1:0]  byte_addr;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
  } stage_t;

  function automatic logic is_misaligned(input logic       mem_to_reg,
                                         input logic [2:0] load_type,
                                         input logic [1:0] byte_addr);
    logic bad_addr;
    case (load_type)
      LOAD_LB, LOAD_LBU:  bad_addr = 1'b0;
      LOAD_LH, LOAD_LHU:  bad_addr = byte_addr[0];
      default:            bad_addr = (byte_addr != 2'b00);
    endcase
    return mem_to_reg && bad_addr;
  endfunction

endpackage

// File: rtl/writeback_etapa_if.sv
// MEM->WB pipeline bus: stage control, incoming instruction fields and the
// register-bank write port plus status outputs.
interface writeback_etapa_if
  import writeback_etapa_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             stall;
  logic             flush;
  logic             in_valid;
  logic             in_regWrite;
  logic             in_memToReg;
  logic [2:0]       in_loadType;
  logic [1:0]       in_byteAddr;
  logic [4:0]       in_writeReg;
  logic [31:0]      in_aluResult;
  logic [31:0]      in_memData;

  logic             regWrite;
  logic [4:0]       writeReg;
  logic [31:0]      writeData;
  logic             addrError;
  logic [CNT_W-1:0] retired;

  modport master (
    output stall, flush, in_valid, in_regWrite, in_memToReg, in_loadType,
           in_byteAddr, in_writeReg, in_aluResult, in_memData,
    input  regWrite, writeReg, writeData, addrError, retired
  );

  modport slave (
    input  stall, flush, in_valid, in_regWrite, in_memToReg, in_loadType,
           in_byteAddr, in_writeReg, in_aluResult, in_memData,
    output regWrite, writeReg, writeData, addrError, retired
  );

endinterface

// File: rtl/writeback_etapa_extractor.sv
// Load alignment and extension: picks the byte/halfword addressed by the low
// address bits out of the raw memory word and sign- or zero-extends it.
module writeback_etapa_extractor
  import writeback_etapa_pkg::*;
#(
  parameter bit BIG_ENDIAN = DEFAULT_BIG_ENDIAN
) (
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_byte_addr,
  input  logic [31:0] i_mem_data,
  output logic [31:0] o_value
);

  // Big-endian lane k lives at physical byte 3-k, which is ~k for two bits.
  function automatic logic [7:0] lane(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] phys;
    phys = BIG_ENDIAN ? ~idx : idx;
    return word[{phys, 3'b000} +: 8];
  endfunction

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = lane(i_mem_data, i_byte_addr);
  assign w_half = {lane(i_mem_data, {i_byte_addr[1], ~BIG_ENDIAN}),
                   lane(i_mem_data, {i_byte_addr[1],  BIG_ENDIAN})};

  // NOTE: o_value is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_value = i_mem_data;
    case (i_load_type)
      LOAD_LB:  o_value = {{24{w_byte[7]}}, w_byte};
      LOAD_LBU: o_value = {24'h000000, w_byte};
      LOAD_LH:  o_value = {{16{w_half[15]}}, w_half};
      LOAD_LHU: o_value = {16'h0000, w_half};
      default:  o_value = i_mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_etapa.sv
// Writeback pipeline stage: one stage register with stall/flush control,
// load extraction, misalignment detection and a retired-instruction counter.
module writeback_etapa
  import writeback_etapa_pkg::*;
#(
  parameter bit BIG_ENDIAN = DEFAULT_BIG_ENDIAN,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  writeback_etapa_if.slave bus
);

  logic             r_valid;
  stage_t           r_stage;
  logic [CNT_W-1:0] r_retired;

  logic             w_capture;
  logic             w_advance;
  logic             w_misaligned;
  logic [31:0]      w_load_value;

  assign w_capture = !bus.stall && !bus.flush;
  // An instruction leaves the stage when it is replaced or flushed.
  assign w_advance = r_valid && (!bus.stall || bus.flush);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_retired <= '0;
    end else begin
      if (bus.flush) begin
        r_valid <= 1'b0;
      end else if (!bus.stall) begin
        r_valid <= bus.in_valid;
      end
      if (w_advance) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // NOTE: data fields carry no reset; every output that matters is qualified by r_valid.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_stage <= '{
        reg_write:  bus.in_regWrite,
        mem_to_reg: bus.in_memToReg,
        load_type:  bus.in_loadType,
        byte_addr:  bus.in_byteAddr,
        write_reg:  bus.in_writeReg,
        alu_result: bus.in_aluResult,
        mem_data:   bus.in_memData
      };
    end
  end

  writeback_etapa_extractor #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_extractor (
    .i_load_type (r_stage.load_type),
    .i_byte_addr (r_stage.byte_addr),
    .i_mem_data  (r_stage.mem_data),
    .o_value     (w_load_value)
  );

  assign w_misaligned = is_misaligned(r_stage.mem_to_reg, r_stage.load_type,
                                      r_stage.byte_addr);

  // Register 0 is hard-wired, so writes to it are suppressed here.
  assign bus.regWrite  = r_valid && r_stage.reg_write &&
                         (r_stage.write_reg != 5'd0) && !w_misaligned;
  assign bus.writeReg  = r_stage.write_reg;
  assign bus.writeData = r_stage.mem_to_reg ? w_load_value : r_stage.alu_result;
  assign bus.addrError = r_valid && w_misaligned;
  assign bus.retired   = r_retired;

endmodule

// File: doc/writeback_etapa.md
WRITEBACK_ETAPA -- requirements
Module: WRITEBACK_etapa

Interface
REQ-001 Parameter BIG_ENDIAN, default 1, meaning: byte lane 0 = memData[31:24] when 1, memData[7:0] when 0.
REQ-002 Parameter CNT_W, default 32, meaning: width of the retired-instruction counter.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold stage contents.
REQ-006 flush  in  1  invalidate stage contents.
REQ-007 in_valid  in  1  MEM-stage instruction present.
REQ-008 in_regWrite  in  1  instruction writes a register.
REQ-009 in_memToReg  in  1  result source: 1 = memory data, 0 = ALU result.
REQ-010 in_loadType  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101-111 treated as LW.
REQ-011 in_byteAddr  in  2  low address bits of the load.
REQ-012 in_writeReg  in  5  destination register.
REQ-013 in_aluResult  in  32  ALU result.
REQ-014 in_memData  in  32  raw memory word.
REQ-015 regWrite  out  1  write enable to register bank.
REQ-016 writeReg  out  5  write address to register bank.
REQ-017 writeData  out  32  write data to register bank.
REQ-018 addrError  out  1  misaligned load held in stage.
REQ-019 retired  out  CNT_W  count of valid instructions leaving the stage.

Function
REQ-020 Stage register (valid_q plus all in_* fields) SHALL capture inputs on the rising edge when stall=0 and flush=0.
REQ-021 When stall=1 and flush=0, the stage register SHALL hold its contents.
REQ-022 When flush=1, valid_q SHALL clear next edge regardless of stall; flush has priority over stall and over capture.
REQ-023 Outputs SHALL be combinational from the stage register only; latency in_* -> outputs = 1 cycle.
REQ-024 Misaligned load: memToReg_q=1 and (LW with byteAddr_q != 00, or LH/LHU with byteAddr_q[0]=1).
REQ-025 addrError SHALL equal valid_q AND misaligned.
REQ-026 regWrite SHALL equal valid_q AND regWrite_q AND (writeReg_q != 0) AND NOT misaligned.
REQ-027 writeReg SHALL equal writeReg_q at all times.
REQ-028 writeData SHALL equal aluResult_q when memToReg_q=0.
REQ-029 When memToReg_q=1, writeData SHALL equal the extracted load value.
REQ-030 LB/LBU: selected byte at lane byteAddr_q, sign- or zero-extended to 32 bits.
REQ-031 LH/LHU: selected halfword at lanes {byteAddr_q[1],0} and {byteAddr_q[1],1}, sign- or zero-extended.
REQ-032 Lane-to-bit mapping SHALL follow BIG_ENDIAN.
REQ-033 During stall, outputs SHALL be held; a repeated identical register write is permitted.
REQ-034 retired SHALL increment by 1 on each edge where valid_q=1 and (stall=0 or flush=1), including misaligned and non-writing instructions.
REQ-035 retired SHALL wrap from all-ones to 0 without a flag.

Reset
REQ-036 On reset=1 at a rising edge: valid_q=0 and retired=0.
REQ-037 Consequently regWrite=0 and addrError=0 from the first cycle after reset.
REQ-038 Data fields need not reset; writeReg/writeData are don't-care while regWrite=0.
REQ-039 Reset SHALL override stall and flush, and SHALL discard any in-flight instruction mid-operation.

Structure
REQ-040 Load-type codes and the BIG_ENDIAN default SHALL live in a shared constants package used by the decode and memory stages.
REQ-041 Load alignment/extension SHALL be one combinational sub-module, WRITEBACK_extractor (inputs: loadType, byteAddr, memData; output: 32-bit value).

Verification
REQ-042 ALU writeback: in_valid=1, regWrite=1, memToReg=0, writeReg=5, aluResult=32'h12345678 -> next cycle regWrite=1, writeReg=5, writeData=32'h12345678, retired +1 on the following advance.
REQ-043 LB sign-extend, BIG_ENDIAN=1: memData=32'h11F23344, byteAddr=01 -> writeData=32'hFFFFFFF2; same with LBU -> 32'h000000F2.
REQ-044 LH at byteAddr=10, memData=32'hAAAA8001 -> writeData=32'hFFFF8001; LH at byteAddr=01 -> addrError=1, regWrite=0.
REQ-045 writeReg=0 with regWrite=1 and aluResult=32'hFFFFFFFF -> regWrite output 0; register 0 in the bank remains 0.
REQ-046 stall=1 for 3 cycles -> outputs hold and retired is unchanged; stall=1 and flush=1 together -> valid_q=0 next edge and retired +1.
REQ-047 Reset asserted mid-stream with valid_q=1 -> next cycle regWrite=0, retired=0; retired preloaded to all-ones plus one advance -> 0.
